pcpi_issuer: RTL

PCPI_ISSUER -- requirements
Module: pcpi_issuer

---
 rtl/m_ext_pkg.sv | 50 +++++
 rtl/pcpi_issuer_encoder.sv | 23 ++
 rtl/pcpi_issuer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/m_ext_pkg.sv
// Shared definitions for the M-extension PCPI issuer: opcodes, funct7 codes,
// func3 enums, issuer FSM states and the R-type encoder helper.
package m_ext_pkg;

    localparam int XLEN            = 32;
    localparam int PCPI_WAIT_LIMIT = 16;

    localparam logic [6:0] OPC_OP            = 7'b0110011;
    localparam logic [6:0] OPC_CUSTOM0       = 7'b0001011;
    localparam logic [6:0] FUNCT7_MULDIV     = 7'b0000001;
    localparam logic [6:0] FUNCT7_CUSTOM_ISTR = 7'b0000000;

    // Highest func3 code the custom eplrr unit implements.
    localparam logic [2:0] CUSTOM_FUNC3_MAX  = 3'b010;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } func3_t;

    typedef enum logic [2:0] {
        CI_EPLRR0 = 3'b000,
        CI_EPLRR1 = 3'b001,
        CI_EPLRR2 = 3'b010
    } custom_inst_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } issuer_state_t;

    function automatic logic [31:0] encode_rtype(
        input logic [6:0] funct7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] func3,
        input logic [4:0] rd,
        input logic [6:0] opcode
    );
        return {funct7, rs2, rs1, func3, rd, opcode};
    endfunction

endpackage

// File: rtl/pcpi_issuer_encoder.sv
// Combinational R-type encoder for MULDIV and custom eplrr requests; flags
// custom func3 codes the coprocessor does not implement.
module pcpi_insn_encoder
    import m_ext_pkg::*;
(
    input  logic        i_custom,
    input  logic [2:0]  i_func3,
    input  logic [4:0]  i_rs1_idx,
    input  logic [4:0]  i_rs2_idx,
    input  logic [4:0]  i_rd_idx,
    output logic [31:0] o_insn,
    output logic        o_illegal
);

    logic [6:0] w_funct7;
    logic [6:0] w_opcode;

    assign w_funct7  = i_custom ? FUNCT7_CUSTOM_ISTR : FUNCT7_MULDIV;
    assign w_opcode  = i_custom ? OPC_CUSTOM0 : OPC_OP;
    assign o_insn    = encode_rtype(w_funct7, i_rs2_idx, i_rs1_idx, i_func3, i_rd_idx, w_opcode);
    assign o_illegal = i_custom && (i_func3 > CUSTOM_FUNC3_MAX);

endmodule

// File: rtl/pcpi_issuer.sv
// Issues one host request at a time to a PCPI coprocessor and returns its result.
// Optional abort of a silent coprocessor is enabled by defining PCPI_ISSUER_TIMEOUT_EN.
module pcpi_issuer #(
    parameter int XLEN       = m_ext_pkg::XLEN,
    parameter int WAIT_LIMIT = m_ext_pkg::PCPI_WAIT_LIMIT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_custom,
    input  logic [2:0]      req_func3,
    input  logic [4:0]      req_rs1_idx,
    input  logic [4:0]      req_rs2_idx,
    input  logic [4:0]      req_rd_idx,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            pcpi_valid,
    output logic [31:0]     pcpi_insn,
    output logic [XLEN-1:0] pcpi_rs1,
    output logic [XLEN-1:0] pcpi_rs2,
    input  logic            pcpi_wr,
    input  logic [XLEN-1:0] pcpi_rd,
    input  logic            pcpi_wait,
    input  logic            pcpi_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_wr,
    output logic            rsp_err
);
    import m_ext_pkg::*;

    // Both handshakes transfer on a rising edge where valid and ready are high;
    // valid, once raised, holds its payload stable until that edge.

    issuer_state_t   r_state;
    issuer_state_t   w_state_nxt;

    logic [31:0]     r_insn;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_rsp_data;
    logic            r_rsp_wr;
    logic            r_rsp_err;

    logic [31:0]     w_enc_insn;
    logic            w_enc_illegal;
    logic            w_accept;
    logic            w_issue;
    logic            w_timeout;

    pcpi_insn_encoder u_encoder (
        .i_custom  (req_custom),
        .i_func3   (req_func3),
        .i_rs1_idx (req_rs1_idx),
        .i_rs2_idx (req_rs2_idx),
        .i_rd_idx  (req_rd_idx),
        .o_insn    (w_enc_insn),
        .o_illegal (w_enc_illegal)
    );

    assign req_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_issue   = (r_state == ST_ISSUE);

`ifdef PCPI_ISSUER_TIMEOUT_EN
    localparam int CW = $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] r_wait_cnt;

    // The limit cycle is the one that would bring the silent count to WAIT_LIMIT;
    // a pcpi_ready in that same cycle still completes normally.
    assign w_timeout = w_issue && !pcpi_ready && !pcpi_wait &&
                       (r_wait_cnt == CW'(WAIT_LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!w_issue || pcpi_wait || pcpi_ready || w_timeout) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    logic w_unused_wait;

    assign w_unused_wait = pcpi_wait;
    assign w_timeout     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_enc_illegal ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pcpi_ready || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_insn     <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rsp_data <= '0;
            r_rsp_wr   <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_insn <= w_enc_insn;
                r_rs1  <= req_rs1;
                r_rs2  <= req_rs2;
                if (w_enc_illegal) begin
                    r_rsp_data <= '0;
                    r_rsp_wr   <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end
            end
            // Coprocessor inputs only matter while a request is outstanding.
            if (w_issue) begin
                if (pcpi_ready) begin
                    r_rsp_data <= pcpi_rd;
                    r_rsp_wr   <= pcpi_wr;
                    r_rsp_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_data <= '0;
                    r_rsp_wr   <= 1'b0;
                    r_rsp_err  <= 1'b1;
                end
            end
        end
    end

    assign pcpi_valid = w_issue;
    assign pcpi_insn  = w_issue ? r_insn : '0;
    assign pcpi_rs1   = w_issue ? r_rs1 : '0;
    assign pcpi_rs2   = w_issue ? r_rs2 : '0;

    assign rsp_valid  = (r_state == ST_RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_wr     = r_rsp_wr;
    assign rsp_err    = r_rsp_err;

endmodule
